// File: rtl/pci_target_mem_if.sv
// ============================================================================
// Module   : pci_target_mem_if
// Purpose  : Control and handshake signals of a PCI bus segment, shared by an
//            initiator (master) and a memory target (slave). The multiplexed
//            AD bus is a resolved tri-state net and is kept outside this
//            bundle as a plain inout port.
// Signals  : FRAME_N  initiator frame, active-low
//            IRDY_N   initiator ready, active-low
//            CBE_N    command (address phase) / byte enables (data phases)
//            DEVSEL_N device select, active-low
//            TRDY_N   target ready, active-low
//            STOP_N   target disconnect, active-low
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pci_target_mem_if;
    logic       FRAME_N;
    logic       IRDY_N;
    logic [3:0] CBE_N;
    logic       DEVSEL_N;
    logic       TRDY_N;
    logic       STOP_N;

    modport master (
        output FRAME_N, IRDY_N, CBE_N,
        input  DEVSEL_N, TRDY_N, STOP_N
    );

    modport slave (
        input  FRAME_N, IRDY_N, CBE_N,
        output DEVSEL_N, TRDY_N, STOP_N
    );
endinterface

`default_nettype wire

// File: rtl/pci_target_mem.sv
// ============================================================================
// Module   : pci_target_mem
// Purpose  : PCI memory-space target backed by a DEPTH x 32 register file.
//            Decodes memory read (0110) / memory write (0111) bursts at
//            BASE_ADDR, one-cycle decode, one turnaround cycle on reads,
//            zero wait states between data phases.
// Ports    : CLK  bus clock (rising edge)
//            RST  asynchronous active-low reset
//            bus  control/handshake bundle (slave modport)
//            AD   multiplexed address/data, driven only in read data phases
// Options  : PCI_TARGET_WRAP_EN - when defined, a burst running past the last
//            word wraps to word 0; otherwise the target disconnects (STOP_N)
//            after the transfer at the last word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  wire              CLK,
    input  wire              RST,
    pci_target_mem_if.slave  bus,
    inout  wire  [31:0]      AD
);
    localparam int          PW             = $clog2(DEPTH);
    localparam logic [31:0] C_SPAN         = 32'(4 * DEPTH);
    localparam logic [3:0]  C_CMD_MEM_RD   = 4'b0110;
    localparam logic [3:0]  C_CMD_MEM_WR   = 4'b0111;
`ifdef PCI_TARGET_WRAP_EN
    // Wrapping relies on the natural roll-over of the PW-bit pointer.
`else
    localparam logic [PW-1:0] C_LAST_WORD  = PW'(DEPTH - 1);
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUSY = 3'd1,
        TAR  = 3'd2,
        DATA = 3'd3,
        DISC = 3'd4
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic          r_is_read;
    logic          r_frame_q;    // FRAME_N on the previous edge
    logic          r_devsel_n;
    logic          r_trdy_n;
    logic          r_stop_n;
    logic          r_ad_oe;
    logic [31:0]   r_ad_out;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   w_offset;
    logic          w_addr_phase;
    logic          w_hit;
    logic [PW-1:0] w_new_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_xfer;

    assign w_offset     = AD - BASE_ADDR;
    // A new address phase needs a falling FRAME_N; r_frame_q resets low so a
    // transaction interrupted by reset is never picked up half-way.
    assign w_addr_phase = (r_state == IDLE) && !bus.FRAME_N && r_frame_q;
    assign w_hit        = ((bus.CBE_N == C_CMD_MEM_RD) || (bus.CBE_N == C_CMD_MEM_WR))
                          && (AD[1:0] == 2'b00)
                          && (AD >= BASE_ADDR) && (w_offset < C_SPAN);
    assign w_new_ptr    = w_offset[PW+1:2];
    assign w_next_ptr   = r_ptr + 1'b1;
    assign w_xfer       = (r_state == DATA) && !r_trdy_n && !bus.IRDY_N;

    assign AD           = r_ad_oe ? r_ad_out : 'z;
    assign bus.DEVSEL_N = r_devsel_n;
    assign bus.TRDY_N   = r_trdy_n;
    assign bus.STOP_N   = r_stop_n;

    // Storage is deliberately not reset: completed writes survive RST.
    always_ff @(posedge CLK) begin
        if (w_xfer && !r_is_read) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.CBE_N[i]) begin
                    mem[r_ptr][8*i +: 8] <= AD[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_is_read  <= 1'b0;
            r_frame_q  <= 1'b0;
            r_devsel_n <= 1'b1;
            r_trdy_n   <= 1'b1;
            r_stop_n   <= 1'b1;
            r_ad_oe    <= 1'b0;
            r_ad_out   <= '0;
        end else begin
            r_frame_q <= bus.FRAME_N;
            case (r_state)
                IDLE: begin
                    if (w_addr_phase) begin
                        if (w_hit) begin
                            r_ptr      <= w_new_ptr;
                            r_devsel_n <= 1'b0;
                            if (bus.CBE_N == C_CMD_MEM_RD) begin
                                r_is_read <= 1'b1;
                                r_state   <= TAR;
                            end else begin
                                r_is_read <= 1'b0;
                                r_trdy_n  <= 1'b0;
                                r_state   <= DATA;
                            end
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Wait out a transaction that belongs to someone else.
                    if (bus.FRAME_N && bus.IRDY_N) begin
                        r_state <= IDLE;
                    end
                end
                TAR: begin
                    r_state  <= DATA;
                    r_trdy_n <= 1'b0;
                    r_ad_oe  <= 1'b1;
                    r_ad_out <= mem[r_ptr];
                end
                DATA: begin
                    if (w_xfer) begin
                        if (bus.FRAME_N) begin
                            r_state    <= IDLE;
                            r_devsel_n <= 1'b1;
                            r_trdy_n   <= 1'b1;
                            r_ad_oe    <= 1'b0;
`ifdef PCI_TARGET_WRAP_EN
                        end else begin
                            r_ptr    <= w_next_ptr;
                            r_ad_out <= mem[w_next_ptr];
                        end
`else
                        end else if (r_ptr == C_LAST_WORD) begin
                            r_state  <= DISC;
                            r_trdy_n <= 1'b1;
                            r_stop_n <= 1'b0;
                            r_ad_oe  <= 1'b0;
                        end else begin
                            r_ptr    <= w_next_ptr;
                            r_ad_out <= mem[w_next_ptr];
                        end
`endif
                    end
                end
                DISC: begin
                    if (bus.FRAME_N) begin
                        r_state    <= IDLE;
                        r_stop_n   <= 1'b1;
                        r_devsel_n <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pci_target_mem.sv
// ============================================================================
// Module   : tb_pci_target_mem
// Purpose  : Self-checking bench for pci_target_mem (BASE_ADDR 0x1000,
//            DEPTH 8). Read tasks push expected data into a queue; a monitor
//            pops and compares on every read transfer. Control signals are
//            checked directly against hand-computed values.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pci_target_mem;
    localparam logic [31:0] HIZ = 32'hFFFF_FFFF;   // pulled-up idle AD

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tb_ad;
    logic        tb_ad_oe;
    logic        rd_active;
    wire  [31:0] ad;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pci_target_mem_if bus ();

    assign ad = tb_ad_oe ? tb_ad : 'z;
    pullup pu_ad (ad);

    pci_target_mem #(
        .BASE_ADDR (32'h0000_1000),
        .DEPTH     (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus),
        .AD  (ad)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a read transfer happens at the coming edge.
    always @(negedge clk) begin
        if (rst && rd_active && !bus.TRDY_N && !bus.IRDY_N) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no transfer", ad);
            end else begin
                check("rd_data", ad, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] ctl();
        return {29'd0, bus.DEVSEL_N, bus.TRDY_N, bus.STOP_N};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.FRAME_N = 1'b1;
        bus.IRDY_N  = 1'b1;
        tb_ad_oe    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        bus.FRAME_N = 1'b0;
        bus.IRDY_N  = 1'b1;
        bus.CBE_N   = cmd;
        tb_ad       = a;
        tb_ad_oe    = 1'b1;
        tick();
    endtask

    task automatic wr_phase(input logic [31:0] d, input logic [3:0] be, input logic last);
        bus.FRAME_N = last;
        bus.IRDY_N  = 1'b0;
        bus.CBE_N   = be;
        tb_ad       = d;
        tb_ad_oe    = 1'b1;
        tick();
    endtask

    task automatic wr_start(input logic [31:0] a);
        addr_phase(a, 4'b0111);
        check("wr_decode_ctl", ctl(), 32'd1);
    endtask

    task automatic wr_end();
        check("wr_release_ctl", ctl(), 32'd7);
        idle(1);
    endtask

    task automatic rd_start(input logic [31:0] a);
        addr_phase(a, 4'b0110);
        tb_ad_oe = 1'b0;
        #1;
        check("rd_tar_ctl", ctl(), 32'd3);
        check("rd_tar_ad", ad, HIZ);
        tick();
        rd_active = 1'b1;
        check("rd_data_ctl", ctl(), 32'd1);
    endtask

    task automatic rd_phase(input logic last);
        bus.FRAME_N = last;
        bus.IRDY_N  = 1'b0;
        tick();
    endtask

    task automatic rd_wait(input int n, input logic [31:0] held);
        repeat (n) begin
            bus.IRDY_N = 1'b1;
            check("rd_wait_hold", ad, held);
            tick();
        end
        check("rd_wait_hold", ad, held);
    endtask

    task automatic rd_end();
        check("rd_release_ctl", ctl(), 32'd7);
        check("rd_release_ad", ad, HIZ);
        rd_active = 1'b0;
        idle(1);
    endtask

    logic [31:0] miss_addr [3];
    logic [3:0]  miss_cmd  [3];

    initial begin
        rst = 1'b1; bus.FRAME_N = 1'b1; bus.IRDY_N = 1'b1; bus.CBE_N = 4'hF;
        tb_ad = '0; tb_ad_oe = 1'b0; rd_active = 1'b0;
        #2 rst = 1'b0;
        #2;
        check("reset_ctl", ctl(), 32'd7);
        check("reset_ad", ad, HIZ);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Three-phase write burst to words 0..2
        wr_start(32'h0000_1000);
        wr_phase(32'h0000_0191, 4'b0000, 1'b0);
        wr_phase(32'h0000_5555, 4'b0000, 1'b0);
        wr_phase(32'h0000_5565, 4'b0000, 1'b1);
        wr_end();

        // Partial byte write over word 1
        wr_start(32'h0000_1004);
        wr_phase(32'hAABB_CCDD, 4'b1010, 1'b1);
        wr_end();

        // Fill words 3..7; last transfer lands on the final word with FRAME_N high
        wr_start(32'h0000_100C);
        wr_phase(32'h3333_0003, 4'b0000, 1'b0);
        wr_phase(32'h4444_0004, 4'b0000, 1'b0);
        wr_phase(32'h5555_0005, 4'b0000, 1'b0);
        wr_phase(32'h6666_0006, 4'b0000, 1'b0);
        wr_phase(32'h7777_0007, 4'b0000, 1'b1);
        wr_end();

        // No byte enables: word 4 untouched, pointer still advances to word 5
        wr_start(32'h0000_1010);
        wr_phase(32'hFFFF_FFFF, 4'b1111, 1'b0);
        wr_phase(32'h5A5A_0005, 4'b0000, 1'b1);
        wr_end();

        // Read burst of 4 with a 2-cycle initiator wait before phase 2
        exp_q.push_back(32'h0000_0191);
        exp_q.push_back(32'h00BB_55DD);
        exp_q.push_back(32'h0000_5565);
        exp_q.push_back(32'h3333_0003);
        rd_start(32'h0000_1000);
        rd_phase(1'b0);
        rd_wait(2, 32'h00BB_55DD);
        rd_phase(1'b0);
        rd_phase(1'b0);
        rd_phase(1'b1);
        rd_end();

        exp_q.push_back(32'h4444_0004);
        exp_q.push_back(32'h5A5A_0005);
        rd_start(32'h0000_1010);
        rd_phase(1'b0);
        rd_phase(1'b1);
        rd_end();

        // Burst running off the end of memory
`ifdef PCI_TARGET_WRAP_EN
        exp_q.push_back(32'h6666_0006);
        exp_q.push_back(32'h7777_0007);
        exp_q.push_back(32'h0000_0191);
        exp_q.push_back(32'h00BB_55DD);
        rd_start(32'h0000_1018);
        rd_phase(1'b0);
        rd_phase(1'b0);
        rd_phase(1'b0);
        rd_phase(1'b1);
        rd_end();
`else
        exp_q.push_back(32'h6666_0006);
        exp_q.push_back(32'h7777_0007);
        rd_start(32'h0000_1018);
        rd_phase(1'b0);
        rd_phase(1'b0);
        check("disc_ctl", ctl(), 32'd2);
        check("disc_ad", ad, HIZ);
        rd_phase(1'b0);
        check("disc_hold_ctl", ctl(), 32'd2);
        rd_phase(1'b1);
        rd_end();
`endif

        // Out-of-range, foreign command and unaligned address are ignored
        miss_addr = '{32'h0000_1020, 32'h0000_1000, 32'h0000_1002};
        miss_cmd  = '{4'b0110, 4'b0010, 4'b0110};
        for (int m = 0; m < 3; m++) begin
            addr_phase(miss_addr[m], miss_cmd[m]);
            tb_ad_oe = 1'b0;
            bus.IRDY_N = 1'b0;
            #1;
            check("miss_ctl", ctl(), 32'd7);
            check("miss_ad", ad, HIZ);
            tick();
            check("miss_ctl", ctl(), 32'd7);
            bus.FRAME_N = 1'b1;
            tick();
            check("miss_ad", ad, HIZ);
            idle(1);
        end
        exp_q.push_back(32'h00BB_55DD);
        rd_start(32'h0000_1004);
        rd_phase(1'b1);
        rd_end();

        // Asynchronous reset in the middle of a read data phase
        rd_start(32'h0000_1000);
        check("pre_reset_ad", ad, 32'h0000_0191);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ctl", ctl(), 32'd7);
        check("async_rst_ad", ad, HIZ);
        rd_active = 1'b0;
        // FRAME_N still low with a hitting address: must not be decoded
        tb_ad = 32'h0000_1000; bus.CBE_N = 4'b0110; tb_ad_oe = 1'b1; bus.FRAME_N = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("stale_frame_ctl", ctl(), 32'd7);
        idle(2);

        wr_start(32'h0000_101C);
        wr_phase(32'hDEAD_0007, 4'b0000, 1'b1);
        wr_end();
        exp_q.push_back(32'h6666_0006);
        exp_q.push_back(32'hDEAD_0007);
        rd_start(32'h0000_1018);
        rd_phase(1'b0);
        rd_phase(1'b1);
        rd_end();
        exp_q.push_back(32'h0000_0191);
        rd_start(32'h0000_1000);
        rd_phase(1'b1);
        rd_end();

        idle(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

`default_nettype wire
